// File: rtl/encoder_pkg.sv
// encoder_pkg: shared index-width helper and priority-mode constants
package encoder_pkg;
  localparam bit MSB_FIRST = 1'b1;
  localparam bit LSB_FIRST = 1'b0;
  function automatic int idx_w(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/prio_enc_comb.sv
// prio_enc_comb: combinational find-first with zero and multi-hot flags
module prio_enc_comb #(
  parameter int N = 8,
  parameter bit MSB_FIRST = encoder_pkg::MSB_FIRST,
  localparam int W = encoder_pkg::idx_w(N)
) (
  input  logic [N-1:0] data,
  output logic [W-1:0] idx,
  output logic         zero,
  output logic         multi
);
  // scan toward the winning end so the last hit seen is the winner
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++)
      if (data[MSB_FIRST ? i : N-1-i]) idx = W'(MSB_FIRST ? i : N-1-i);
  end
  assign zero  = ~|data;
  assign multi = |(data & (data - N'(1)));
endmodule

// File: rtl/priority_encoder_pipe.sv
// priority_encoder_pipe: one-stage registered priority encoder with error counter
module priority_encoder_pipe #(
  parameter int N = 8,
  parameter bit MSB_FIRST = encoder_pkg::MSB_FIRST,
  parameter int CNT_W = 8,
  localparam int W = encoder_pkg::idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_idx,
  output logic             out_zero,
  output logic             out_multi,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_count
);
  logic [W-1:0] c_idx;
  logic c_zero, c_multi, xfer;
  prio_enc_comb #(.N(N), .MSB_FIRST(MSB_FIRST)) u_enc (
    .data(in_data), .idx(c_idx), .zero(c_zero), .multi(c_multi)
  );
  assign in_ready = (!out_valid || out_ready) && !rst;
  assign xfer = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_zero  <= 1'b0;
      out_multi <= 1'b0;
      err_count <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_idx   <= c_idx;
        out_zero  <= c_zero;
        out_multi <= c_multi;
      end else if (out_ready) out_valid <= 1'b0;
      if (clr_err) err_count <= '0;
      else if (xfer && (c_zero || c_multi) && err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end
endmodule
